player_move_ctrl: RTL



---
 rtl/player_pkg.sv | 36 +++
 rtl/player_move_ctrl_if.sv | 28 ++
 rtl/key_debounce.sv | 43 ++++
 rtl/player_move_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the player movement path: direction codes, move-controller
// FSM states and the default 50 MHz timing constants.
package player_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DELAY        = 2'd1,
        ST_REPEAT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 7500000;
    localparam int DEF_CNT_W           = 25;

    // Fixed priority among held keys: up > down > left > right (bit index = dir code).
    function automatic dir_t prio_dir(input logic [3:0] lvl);
        if (lvl[DIR_UP])        return DIR_UP;
        else if (lvl[DIR_DOWN]) return DIR_DOWN;
        else if (lvl[DIR_LEFT]) return DIR_LEFT;
        else                    return DIR_RIGHT;
    endfunction

    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Key inputs, enable and move-pulse outputs of the player move controller.
// Handshake: none; keys are raw levels, each move output is a one-cycle strobe valid when high.
interface player_move_ctrl_if;
    import player_pkg::*;

    logic   enable;
    logic   key_up;
    logic   key_down;
    logic   key_left;
    logic   key_right;
    logic   up;
    logic   down;
    logic   left;
    logic   right;
    state_t dbg_state;
    dir_t   dbg_dir;

    modport master (
        output enable, key_up, key_down, key_left, key_right,
        input  up, down, left, right, dbg_state, dbg_dir
    );

    modport slave (
        input  enable, key_up, key_down, key_left, key_right,
        output up, down, left, right, dbg_state, dbg_dir
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push button.
// The level flips once the synchronised input has disagreed for DEBOUNCE_CYCLES samples.
module key_debounce
    import player_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_level
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            // Any agreeing sample restarts the stability run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/player_move_ctrl.sv
// Turns four raw direction buttons into single-cycle move pulses with one-direction
// locking and hold-to-repeat; enable low suppresses movement until all keys are released.
module player_move_ctrl
    import player_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic              clk,
    input logic              reset,
    player_move_ctrl_if.slave bus
);

    logic [3:0]       w_raw;
    logic [3:0]       w_lvl;
    logic             w_any;
    dir_t             w_prio;

    state_t           r_state;
    dir_t             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pulse;

    assign w_raw = {bus.key_right, bus.key_left, bus.key_down, bus.key_up};

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .i_key   (w_raw[g]),
            .o_level (w_lvl[g])
        );
    end

    assign w_any  = |w_lvl;
    assign w_prio = prio_dir(w_lvl);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_UP;
            r_cnt   <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            // A key still held while disabled must be released before it can fire again.
            if (!bus.enable) begin
                r_state <= w_any ? ST_WAIT_RELEASE : ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_any) begin
                            r_dir   <= w_prio;
                            r_pulse <= dir_onehot(w_prio);
                            r_cnt   <= CNT_W'(REPEAT_DELAY);
                            r_state <= ST_DELAY;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (!w_lvl[r_dir]) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt <= CNT_W'(1)) begin
                            r_pulse <= dir_onehot(r_dir);
                            r_cnt   <= CNT_W'(REPEAT_PERIOD);
                            r_state <= ST_REPEAT;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_WAIT_RELEASE: begin
                        if (!w_any) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.up        = r_pulse[DIR_UP];
    assign bus.down      = r_pulse[DIR_DOWN];
    assign bus.left      = r_pulse[DIR_LEFT];
    assign bus.right     = r_pulse[DIR_RIGHT];
    assign bus.dbg_state = r_state;
    assign bus.dbg_dir   = r_dir;

endmodule
